// File: rtl/dcache_req_buffer_pkg.sv
// Shared data-cache request definitions: access-size codes, CACOP width,
// buffer occupancy states, the stored entry layout and the strobe helper.
package dcache_req_buffer_pkg;

  localparam logic [3:0] SIZE_BYTE    = 4'b0001;
  localparam logic [3:0] SIZE_HALF    = 4'b0011;
  localparam logic [3:0] SIZE_WORD    = 4'b1111;
  localparam int         CACOP_CODE_W = 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

  typedef struct packed {
    logic [31:0]             addr;
    logic [3:0]              size;
    logic                    we;
    logic [3:0]              wstrb;
    logic [31:0]             wdata;
    logic                    cacop_en;
    logic [CACOP_CODE_W-1:0] cacop_code;
  } req_entry_t;

  // Byte-lane strobe for an aligned access; misaligned or unknown sizes write nothing.
  function automatic logic [3:0] lane_strobe(input logic [3:0] size, input logic [1:0] offset);
    logic [3:0] strb;
    case (size)
      SIZE_WORD: strb = (offset == 2'b00) ? 4'b1111 : 4'b0000;
      SIZE_HALF: strb = offset[0] ? 4'b0000 : (4'b0011 << {offset[1], 1'b0});
      SIZE_BYTE: strb = 4'b0001 << offset;
      default:   strb = 4'b0000;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/dcache_wstrb_gen.sv
// Combinational store-strobe and lane-replicated write-data generator.
module dcache_wstrb_gen
  import dcache_req_buffer_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [3:0]  size,
  input  logic        we,
  input  logic        cacop_en,
  input  logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep
);

  // Only plain stores drive byte lanes; loads and CACOPs never write.
  always_comb begin
    wstrb = 4'b0000;
    if (we && !cacop_en) begin
      wstrb = lane_strobe(size, addr_lo);
    end else begin
      wstrb = 4'b0000;
    end
  end

  // Replicate narrow store data across every lane so any strobe picks the right bytes.
  always_comb begin
    wdata_rep = wdata;
    case (size)
      SIZE_BYTE: wdata_rep = {4{wdata[7:0]}};
      SIZE_HALF: wdata_rep = {2{wdata[15:0]}};
      SIZE_WORD: wdata_rep = wdata;
      default:   wdata_rep = wdata;
    endcase
  end

endmodule

// File: rtl/dcache_req_buffer.sv
// Two-entry request buffer in front of the data cache. Holds requests in
// FIFO order and presents the head entry on the *_rbuf outputs.
module dcache_req_buffer
  import dcache_req_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_addr,
  input  logic [3:0]              in_type,
  input  logic                    in_we,
  input  logic [31:0]             in_wdata,
  input  logic                    in_cacop_en,
  input  logic [CACOP_CODE_W-1:0] in_cacop_code,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             addr_rbuf,
  output logic [3:0]              type_rbuf,
  output logic                    we_rbuf,
  output logic [3:0]              wstrb_rbuf,
  output logic [31:0]             wdata_rbuf,
  output logic                    cacop_en_rbuf,
  output logic [CACOP_CODE_W-1:0] cacop_code_rbuf
);

  occ_state_e  state_r;
  logic        head_ptr_r;
  req_entry_t  entry_r [DEPTH];

  logic        push_s;
  logic        pop_s;
  logic        wr_ptr_s;
  logic [3:0]  wstrb_s;
  logic [31:0] wdata_rep_s;
  req_entry_t  new_entry_s;
  req_entry_t  head_s;

  dcache_wstrb_gen u_wstrb_gen (
    .addr_lo   (in_addr[1:0]),
    .size      (in_type),
    .we        (in_we),
    .cacop_en  (in_cacop_en),
    .wdata     (in_wdata),
    .wstrb     (wstrb_s),
    .wdata_rep (wdata_rep_s)
  );

  assign in_ready  = ~rst & (state_r != ST_FULL);
  assign out_valid = (state_r != ST_EMPTY);
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  // Pack the incoming request with its pre-computed strobe and replicated data.
  always_comb begin
    new_entry_s            = '0;
    new_entry_s.addr       = in_addr;
    new_entry_s.size       = in_type;
    new_entry_s.we         = in_we;
    new_entry_s.wstrb      = wstrb_s;
    new_entry_s.wdata      = wdata_rep_s;
    new_entry_s.cacop_en   = in_cacop_en;
    new_entry_s.cacop_code = in_cacop_code;
  end

  // Write slot: the head slot when empty, otherwise the slot behind the head.
  always_comb begin
    wr_ptr_s = head_ptr_r;
    case (state_r)
      ST_EMPTY: wr_ptr_s = head_ptr_r;
      ST_ONE:   wr_ptr_s = ~head_ptr_r;
      default:  wr_ptr_s = head_ptr_r;
    endcase
  end

  // Occupancy FSM, head pointer and entry storage; flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_EMPTY;
      head_ptr_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= '0;
      end
    end else if (flush) begin
      state_r    <= ST_EMPTY;
      head_ptr_r <= 1'b0;
    end else begin
      if (push_s) begin
        entry_r[wr_ptr_s] <= new_entry_s;
      end
      case (state_r)
        ST_EMPTY: begin
          if (push_s) state_r <= ST_ONE;
        end
        ST_ONE: begin
          if (push_s && pop_s) begin
            state_r    <= ST_ONE;
            head_ptr_r <= ~head_ptr_r;
          end else if (push_s) begin
            state_r <= ST_FULL;
          end else if (pop_s) begin
            state_r    <= ST_EMPTY;
            head_ptr_r <= ~head_ptr_r;
          end
        end
        ST_FULL: begin
          if (pop_s) begin
            state_r    <= ST_ONE;
            head_ptr_r <= ~head_ptr_r;
          end
        end
        default: begin
          state_r    <= ST_EMPTY;
          head_ptr_r <= 1'b0;
        end
      endcase
    end
  end

  // Head view is zeroed when empty so the exception checker sees a null request.
  always_comb begin
    head_s = '0;
    if (out_valid) begin
      head_s = entry_r[head_ptr_r];
    end else begin
      head_s = '0;
    end
  end

  assign addr_rbuf       = head_s.addr;
  assign type_rbuf       = head_s.size;
  assign we_rbuf         = head_s.we;
  assign wstrb_rbuf      = head_s.wstrb;
  assign wdata_rbuf      = head_s.wdata;
  assign cacop_en_rbuf   = head_s.cacop_en;
  assign cacop_code_rbuf = head_s.cacop_code;

endmodule

// File: tb/tb_dcache_req_buffer.sv
// Scoreboard testbench for dcache_req_buffer with directed request vectors.
module tb_dcache_req_buffer;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  size;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        cen;
    logic [4:0]  code;
  } exp_t;

  localparam logic [3:0] B = 4'b0001;
  localparam logic [3:0] H = 4'b0011;
  localparam logic [3:0] W = 4'b1111;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_we, in_cacop_en;
  logic [31:0] in_addr, in_wdata;
  logic [3:0]  in_type;
  logic [4:0]  in_cacop_code;
  logic        out_valid, out_ready;
  logic [31:0] addr_rbuf, wdata_rbuf;
  logic [3:0]  type_rbuf, wstrb_rbuf;
  logic        we_rbuf, cacop_en_rbuf;
  logic [4:0]  cacop_code_rbuf;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  dcache_req_buffer #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_type(in_type), .in_we(in_we), .in_wdata(in_wdata),
    .in_cacop_en(in_cacop_en), .in_cacop_code(in_cacop_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .addr_rbuf(addr_rbuf), .type_rbuf(type_rbuf), .we_rbuf(we_rbuf),
    .wstrb_rbuf(wstrb_rbuf), .wdata_rbuf(wdata_rbuf),
    .cacop_en_rbuf(cacop_en_rbuf), .cacop_code_rbuf(cacop_code_rbuf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Offer one request for a cycle; queue its expected head image if it should be taken.
  task automatic send(input logic [31:0] addr, input logic [3:0] size, input logic we,
                      input logic [31:0] wdata, input logic cen, input logic [4:0] code,
                      input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                      input logic exp_accept, input logic do_flush);
    exp_t e;
    in_valid = 1'b1; in_addr = addr; in_type = size; in_we = we; in_wdata = wdata;
    in_cacop_en = cen; in_cacop_code = code; flush = do_flush;
    @(negedge clk);
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_accept});
    if (exp_accept && !do_flush) begin
      e.addr = addr; e.size = size; e.we = we; e.wstrb = exp_strb;
      e.wdata = exp_wdata; e.cen = cen; e.code = code;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare each consumed head against the scoreboard; empty head must read zero.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {32'd0, addr_rbuf}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("addr_rbuf",       {32'd0, addr_rbuf},       {32'd0, e.addr});
          chk("type_rbuf",       {60'd0, type_rbuf},       {60'd0, e.size});
          chk("we_rbuf",         {63'd0, we_rbuf},         {63'd0, e.we});
          chk("wstrb_rbuf",      {60'd0, wstrb_rbuf},      {60'd0, e.wstrb});
          chk("wdata_rbuf",      {32'd0, wdata_rbuf},      {32'd0, e.wdata});
          chk("cacop_en_rbuf",   {63'd0, cacop_en_rbuf},   {63'd0, e.cen});
          chk("cacop_code_rbuf", {59'd0, cacop_code_rbuf}, {59'd0, e.code});
        end
      end else if (!out_valid) begin
        chk("idle_addr_data", {addr_rbuf, wdata_rbuf}, 64'd0);
        chk("idle_ctrl", {50'd0, type_rbuf, we_rbuf, wstrb_rbuf, cacop_en_rbuf, cacop_code_rbuf}, 64'd0);
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_addr = 32'd0; in_type = 4'd0;
    in_we = 1'b0; in_wdata = 32'd0; in_cacop_en = 1'b0; in_cacop_code = 5'd0;
    out_ready = 1'b0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_outputs", {addr_rbuf, wdata_rbuf}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;

    // WORD store, one-cycle latency, then empty again
    out_ready = 1'b1;
    send(32'h100, W, 1'b1, 32'h1234_5678, 1'b0, 5'd0, 4'b1111, 32'h1234_5678, 1'b1, 1'b0);
    @(negedge clk);
    chk("word_out_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("word_then_empty", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;

    // Back-to-back single-cycle stream of distinct sizes/alignments
    send(32'h103, B, 1'b1, 32'h0000_00AB, 1'b0, 5'd0, 4'b1000, 32'hABAB_ABAB, 1'b1, 1'b0);
    send(32'h101, H, 1'b1, 32'h0000_BEEF, 1'b0, 5'd0, 4'b0000, 32'hBEEF_BEEF, 1'b1, 1'b0);
    send(32'h102, H, 1'b1, 32'h0000_CAFE, 1'b0, 5'd0, 4'b1100, 32'hCAFE_CAFE, 1'b1, 1'b0);
    send(32'h101, B, 1'b1, 32'h0000_0012, 1'b0, 5'd0, 4'b0010, 32'h1212_1212, 1'b1, 1'b0);
    send(32'h102, W, 1'b1, 32'hDEAD_BEEF, 1'b0, 5'd0, 4'b0000, 32'hDEAD_BEEF, 1'b1, 1'b0);
    send(32'h200, W, 1'b0, 32'h55AA_55AA, 1'b0, 5'd0, 4'b0000, 32'h55AA_55AA, 1'b1, 1'b0);
    send(32'h204, 4'b0111, 1'b1, 32'h0102_0304, 1'b0, 5'd0, 4'b0000, 32'h0102_0304, 1'b1, 1'b0);
    idle(2);

    // Backpressure: A, B absorbed, C refused; release drains A then B
    out_ready = 1'b0;
    send(32'hA00, W, 1'b1, 32'hAAAA_0001, 1'b0, 5'd0, 4'b1111, 32'hAAAA_0001, 1'b1, 1'b0);
    send(32'hB00, W, 1'b1, 32'hBBBB_0002, 1'b0, 5'd0, 4'b1111, 32'hBBBB_0002, 1'b1, 1'b0);
    send(32'hC00, W, 1'b1, 32'hCCCC_0003, 1'b0, 5'd0, 4'b1111, 32'hCCCC_0003, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_addr_head", {32'd0, addr_rbuf}, 64'hA00);
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(3);

    // Flush in FULL with a request offered: nothing survives
    out_ready = 1'b0;
    send(32'hD00, W, 1'b1, 32'hDDDD_0004, 1'b0, 5'd0, 4'b1111, 32'hDDDD_0004, 1'b1, 1'b0);
    send(32'hE00, W, 1'b1, 32'hEEEE_0005, 1'b0, 5'd0, 4'b1111, 32'hEEEE_0005, 1'b1, 1'b0);
    send(32'hF00, W, 1'b1, 32'hFFFF_0006, 1'b0, 5'd0, 4'b1111, 32'hFFFF_0006, 1'b0, 1'b1);
    exp_q.delete();
    @(negedge clk);
    chk("flush_full_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_full_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Flush in ONE with an acceptable request offered: the offer is dropped
    send(32'h400, W, 1'b1, 32'h4444_0007, 1'b0, 5'd0, 4'b1111, 32'h4444_0007, 1'b1, 1'b0);
    send(32'h404, W, 1'b1, 32'h4444_0008, 1'b0, 5'd0, 4'b1111, 32'h4444_0008, 1'b1, 1'b1);
    exp_q.delete();
    @(negedge clk);
    chk("flush_one_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h500, H, 1'b1, 32'h0000_1357, 1'b0, 5'd0, 4'b0011, 32'h1357_1357, 1'b1, 1'b0);
    idle(2);

    // CACOP store: strobe suppressed, code carried
    send(32'h300, W, 1'b1, 32'h9999_0009, 1'b1, 5'h08, 4'b0000, 32'h9999_0009, 1'b1, 1'b0);
    idle(1);

    // Reset mid-stream discards the contents
    out_ready = 1'b0;
    send(32'h600, W, 1'b1, 32'h6666_000A, 1'b0, 5'd0, 4'b1111, 32'h6666_000A, 1'b1, 1'b0);
    send(32'h604, B, 1'b1, 32'h0000_0077, 1'b1, 5'h1F, 4'b0000, 32'h7777_7777, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_addr_data", {addr_rbuf, wdata_rbuf}, 64'd0);
    chk("rst_mid_ctrl", {50'd0, type_rbuf, we_rbuf, wstrb_rbuf, cacop_en_rbuf, cacop_code_rbuf}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(32'h700, B, 1'b1, 32'h0000_00C3, 1'b0, 5'd0, 4'b0001, 32'hC3C3_C3C3, 1'b1, 1'b0);
    idle(2);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_req_buffer.md
# dcache_req_buffer

Two-entry request buffer at the front of the data cache. It accepts load, store and CACOP requests from the memory pipeline stage over a valid/ready handshake and decouples upstream from cache stalls. It presents the head request as the `*_rbuf` signals consumed by the cache alignment-exception checker and the tag-compare stage. It also pre-computes the store byte strobe and lane-replicated write data.

## Interface
Parameters:
- `DEPTH`, 2: buffer entries; fixed at 2, not a general FIFO.

Ports:
- `clk`  in  1  single clock; every register updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  pipeline flush; discards all buffered requests.
- `in_valid`  in  1  upstream request valid.
- `in_ready`  out  1  buffer can accept a request.
- `in_addr`  in  32  byte address.
- `in_type`  in  4  access size: BYTE=4'b0001, HALF=4'b0011, WORD=4'b1111.
- `in_we`  in  1  1 = store, 0 = load.
- `in_wdata`  in  32  store data, right-aligned.
- `in_cacop_en`  in  1  request is a CACOP.
- `in_cacop_code`  in  5  CACOP operation code.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  cache consumes the head entry.
- `addr_rbuf`  out  32  head address.
- `type_rbuf`  out  4  head access size.
- `we_rbuf`  out  1  head store flag.
- `wstrb_rbuf`  out  4  head byte strobe.
- `wdata_rbuf`  out  32  head lane-replicated write data.
- `cacop_en_rbuf`  out  1  head CACOP flag.
- `cacop_code_rbuf`  out  5  head CACOP code.

## Operation
- Occupancy states: EMPTY (0), ONE (1), FULL (2). Entries are stored in FIFO order, and the head drives all `*_rbuf` outputs.
- Push: `in_valid & in_ready`. Pop: `out_valid & out_ready`.
- `in_ready = ~rst & (state != FULL)`. It is combinational from state only and never depends on `out_ready`.
- `out_valid = (state != EMPTY)`.
- Transitions:
  - EMPTY: push → ONE.
  - ONE:
    - push only → FULL.
    - pop only → EMPTY.
    - push + pop → ONE; the new entry becomes head on the next cycle.
  - FULL:
    - pop → ONE; the second entry becomes head.
    - A push cannot occur because `in_ready` is 0.
- Flush: forces the state to EMPTY next cycle. It has priority over a push or pop in the same cycle, and a request offered in that cycle is dropped.
- Strobe, computed at push time and stored per entry:
  - WORD: 4'b1111.
  - HALF: 4'b0011 << {addr[1],1'b0}.
  - BYTE: 4'b0001 << addr[1:0].
- `wstrb` is forced to 4'b0000 when any of the following holds:
  - `in_we` = 0;
  - `in_cacop_en` = 1;
  - WORD with addr[1:0] ≠ 0;
  - HALF with addr[0] = 1;
  - `in_type` is any other code.

  A misaligned store therefore never writes, independent of the downstream exception.
- Write data:
  - BYTE: {4{wdata[7:0]}}.
  - HALF: {2{wdata[15:0]}}.
  - WORD: unchanged.
  - Other codes: unchanged.
- Empty head: when `out_valid` = 0, all `*_rbuf` outputs read 0. The downstream exception checker then sees `type_rbuf` = 0 and reports no exception.

## Timing
- Latency: a request pushed at edge N appears on `*_rbuf` with `out_valid` = 1 after edge N; there is no combinational path from input to output.
- Throughput: one request per cycle sustained while `out_ready` stays high, with steady-state occupancy ONE.
- Backpressure: when `out_ready` is low, at most 2 requests are absorbed, then `in_ready` drops in the cycle after the second push.
- Reset: while `rst` is high, `in_ready` = 0. The state goes to EMPTY and all outputs are 0 after the edge. Reset mid-operation discards the contents exactly as flush does.
- Head stability: `*_rbuf` outputs hold stable while `out_valid & ~out_ready`.

## Structure
- Size-code constants (BYTE/HALF/WORD) and the CACOP code width belong in the shared cache header, next to `exception.vh`.
- One combinational sub-module, `dcache_wstrb_gen`, computes the strobe and the lane-replicated data. The parent holds the two entry registers, the head pointer and the state.

## Test plan
- Store of WORD 0x1234_5678 to addr 0x100, `out_ready` = 1 → next cycle:
  - `out_valid` = 1, `wstrb_rbuf` = 4'b1111, `wdata_rbuf` = 0x1234_5678;
  - following cycle `out_valid` = 0.
- Store of BYTE 0xAB to addr 0x103 → `wstrb_rbuf` = 4'b1000, `wdata_rbuf` = 0xABAB_ABAB.
- Store of HALF to addr 0x101 → `wstrb_rbuf` = 0, `type_rbuf` = 4'b0011, `addr_rbuf` = 0x101.
- Hold `out_ready` = 0 and push A, B, C back to back:
  - `in_ready` is 0 after B and C is not accepted;
  - release `out_ready` → A, then B, appear in order on consecutive cycles.
- FULL state, assert `flush` together with `in_valid` → next cycle `out_valid` = 0 and `in_ready` = 1, and the offered request is never output.
- CACOP store request (`in_cacop_en` = 1, code 5'h08) → `cacop_en_rbuf` = 1, `cacop_code_rbuf` = 5'h08, `wstrb_rbuf` = 0. Assert `rst` mid-stream → after the edge all outputs are 0.
